// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl
// ---------------------------------------------------------------------------
// Top-level sequencer for the snake game. It runs the IDLE/RUN/PAUSE/OVER
// state machine, generates the periodic snake movement tick, turns the raw
// collision levels into single-cycle goodColl/badColl pulses for
// score_tracker, detects a win from the score read back, and pulses
// clearScore at every game start.
//
// Optional feature macro: GAME_SPEEDUP_EN
//   defined   : RUN tick period is max(TICK_DIV - currScore[6:3], 2),
//               re-sampled at every tick counter wrap.
//   undefined : RUN tick period is fixed at TICK_DIV.
//
// Ports:
//   clk            in   system clock
//   nRst           in   synchronous active-low reset
//   startBtn       in   start/restart button (synchronised level)
//   pauseBtn       in   pause toggle button (synchronised level)
//   appleHit       in   head-on-apple flag (level)
//   wallHit        in   head-on-wall flag (level)
//   selfHit        in   head-on-body flag (level)
//   currScore[6:0] in   current score from score_tracker
//   gameState[1:0] out  00 IDLE, 01 RUN, 10 PAUSE, 11 OVER
//   moveTick       out  one-cycle snake-advance pulse
//   goodColl       out  one-cycle apple pulse to score_tracker
//   badColl        out  one-cycle fatal-collision pulse to score_tracker
//   clearScore     out  one-cycle score clear pulse at game start
//   isGameComplete out  high while in OVER
//   win            out  high in OVER when the game ended on MAX_SCORE
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module game_flow_ctrl #(
  parameter int TICK_DIV  = 10,
  parameter int MAX_SCORE = 50,
  parameter int OVER_HOLD = 4
) (
  input  logic       clk,
  input  logic       nRst,
  input  logic       startBtn,
  input  logic       pauseBtn,
  input  logic       appleHit,
  input  logic       wallHit,
  input  logic       selfHit,
  input  logic [6:0] currScore,
  output logic [1:0] gameState,
  output logic       moveTick,
  output logic       goodColl,
  output logic       badColl,
  output logic       clearScore,
  output logic       isGameComplete,
  output logic       win
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10,
    S_OVER  = 2'b11
  } state_t;

  // Wide enough to hold OVER_HOLD itself (and never zero bits wide).
  localparam int HOLD_W = $clog2(OVER_HOLD + 2);

  state_t            state;
  logic [7:0]        tick_cnt;
  logic [HOLD_W-1:0] hold_cnt;
  logic              start_prev;
  logic              pause_prev;
  logic              apple_prev;
  logic              hit_prev;

  logic start_e;
  logic pause_e;
  logic apple_e;
  logic hit_e;
  logic tick_last;
  logic score_reached;

  assign start_e = startBtn & ~start_prev;
  assign pause_e = pauseBtn & ~pause_prev;
  assign apple_e = appleHit & ~apple_prev;
  assign hit_e   = (wallHit | selfHit) & ~hit_prev;

  // While clearScore is high the score input still shows the previous
  // game's value, so the win check is held off for that one cycle.
  assign score_reached = ~clearScore && (currScore >= 7'(MAX_SCORE));

  assign gameState = state;

`ifdef GAME_SPEEDUP_EN
  logic [7:0] period;
  logic [7:0] next_period;
  logic [7:0] speed_step;

  // One cycle faster per 8 points, never below a 2-cycle period.
  always_comb begin
    speed_step = {4'd0, currScore[6:3]};
    if (8'(TICK_DIV) < speed_step + 8'd2) begin
      next_period = 8'd2;
    end else begin
      next_period = 8'(TICK_DIV) - speed_step;
    end
  end

  assign tick_last = (tick_cnt == period - 8'd1);
`else
  assign tick_last = (tick_cnt == 8'(TICK_DIV - 1));
`endif

  // Game state machine. Pulse outputs default low each cycle, so every
  // pulse lasts exactly one cycle. The tick counter advances on every RUN
  // cycle, including the one that leaves RUN, and is then held frozen in
  // PAUSE so a resumed game picks up where it stopped.
  always_ff @(posedge clk) begin
    if (!nRst) begin
      state          <= S_IDLE;
      tick_cnt       <= 8'd0;
      hold_cnt       <= '0;
      start_prev     <= 1'b0;
      pause_prev     <= 1'b0;
      apple_prev     <= 1'b0;
      hit_prev       <= 1'b0;
      moveTick       <= 1'b0;
      goodColl       <= 1'b0;
      badColl        <= 1'b0;
      clearScore     <= 1'b0;
      isGameComplete <= 1'b0;
      win            <= 1'b0;
`ifdef GAME_SPEEDUP_EN
      period         <= 8'(TICK_DIV);
`endif
    end else begin
      start_prev <= startBtn;
      pause_prev <= pauseBtn;
      apple_prev <= appleHit;
      hit_prev   <= wallHit | selfHit;
      moveTick   <= 1'b0;
      goodColl   <= 1'b0;
      badColl    <= 1'b0;
      clearScore <= 1'b0;

      case (state)
        S_IDLE: begin
          if (start_e) begin
            state      <= S_RUN;
            clearScore <= 1'b1;
            tick_cnt   <= 8'd0;
`ifdef GAME_SPEEDUP_EN
            period     <= 8'(TICK_DIV);
`endif
          end
        end

        S_RUN: begin
          if (tick_last) begin
            tick_cnt <= 8'd0;
`ifdef GAME_SPEEDUP_EN
            period   <= next_period;
`endif
          end else begin
            tick_cnt <= tick_cnt + 8'd1;
          end

          // A fatal hit outranks the win check, the apple and a pause.
          if (hit_e) begin
            badColl        <= 1'b1;
            state          <= S_OVER;
            isGameComplete <= 1'b1;
            win            <= 1'b0;
            hold_cnt       <= '0;
          end else if (score_reached) begin
            state          <= S_OVER;
            isGameComplete <= 1'b1;
            win            <= 1'b1;
            hold_cnt       <= '0;
          end else begin
            goodColl <= apple_e;
            if (pause_e) begin
              state <= S_PAUSE;
            end else begin
              moveTick <= tick_last;
            end
          end
        end

        S_PAUSE: begin
          if (pause_e) begin
            state <= S_RUN;
          end
        end

        S_OVER: begin
          if (hold_cnt != HOLD_W'(OVER_HOLD)) begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end else if (start_e) begin
            state          <= S_RUN;
            clearScore     <= 1'b1;
            isGameComplete <= 1'b0;
            win            <= 1'b0;
            tick_cnt       <= 8'd0;
`ifdef GAME_SPEEDUP_EN
            period         <= 8'(TICK_DIV);
`endif
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/game_flow_ctrl.md
Name: game_flow_ctrl

Overview:
- Top-level game sequencer for the snake game.
- Owns the IDLE/RUN/PAUSE/OVER state machine and generates the snake movement tick.
- Turns raw collision flags from the snake/apple logic into single-cycle goodColl/badColl pulses for score_tracker.
- Reads currScore back from score_tracker to detect a win, and issues a clear pulse at every game start.

Parameters:
- TICK_DIV, default 10: clk cycles per moveTick in RUN; legal range 2..255.
- MAX_SCORE, default 50: currScore value that ends the game as a win; legal range 1..127.
- OVER_HOLD, default 4: cycles spent in OVER before startBtn is accepted again.

Ports:
- clk  in  1  system clock.
- nRst  in  1  synchronous, active-low reset.
- startBtn  in  1  start/restart button, synchronised level.
- pauseBtn  in  1  pause toggle button, synchronised level.
- appleHit  in  1  head-on-apple flag, level.
- wallHit  in  1  head-on-wall flag, level.
- selfHit  in  1  head-on-body flag, level.
- currScore  in  7  current score from score_tracker.
- gameState  out  2  00 IDLE, 01 RUN, 10 PAUSE, 11 OVER.
- moveTick  out  1  one-cycle snake-advance pulse.
- goodColl  out  1  one-cycle pulse to score_tracker.
- badColl  out  1  one-cycle pulse to score_tracker.
- clearScore  out  1  one-cycle pulse; score_tracker zeroes currScore.
- isGameComplete  out  1  high while in OVER.
- win  out  1  high while in OVER if the game ended by reaching MAX_SCORE.

Behaviour:
- Interface:
  - Single clock clk.
  - nRst is synchronous and active-low.
  - All outputs are registered.
- Reset (nRst=0 at a clk edge):
  - gameState=IDLE.
  - moveTick, goodColl, badColl, clearScore, isGameComplete, win all 0.
  - Tick counter, hold counter and all edge-detect registers cleared to 0.
  - Reset mid-game abandons the game immediately; no badColl is emitted.
- Edge detection:
  - startE, pauseE, appleE and hitE (wallHit|selfHit) are each (input & ~prev). prev registers reset to 0.
  - A level held high counts exactly once.
- IDLE:
  - startE -> RUN; clearScore=1 for the first RUN cycle; tick counter=0.
  - pauseE and collisions are ignored.
  - startE and pauseE in the same cycle: start wins, and that pause is discarded.
- RUN:
  - The tick counter counts 0..TICK_DIV-1 and wraps.
  - moveTick=1 in the cycle after the counter equals TICK_DIV-1, giving a period of exactly TICK_DIV cycles.
  - The first moveTick occurs TICK_DIV cycles after entering RUN.
  - appleE -> goodColl=1 the next cycle.
  - hitE -> badColl=1 the next cycle; state -> OVER with win=0.
  - appleE and hitE in the same cycle: badColl only, goodColl=0.
  - pauseE -> PAUSE. If pauseE coincides with hitE, hitE wins and the state goes to OVER.
  - currScore >= MAX_SCORE -> OVER with win=1, no badColl. Checked every RUN cycle; it fires one cycle after score_tracker updates.
  - startE is ignored.
- PAUSE:
  - Tick counter frozen; moveTick=0.
  - Collisions are ignored and their prev registers still update, so a flag held high during PAUSE does not fire on resume.
  - pauseE -> RUN; the counter resumes from its frozen value.
  - startE is ignored.
- OVER:
  - isGameComplete=1; win is held.
  - The hold counter counts up to OVER_HOLD.
  - startE before OVER_HOLD cycles have elapsed is ignored.
  - startE after the hold -> RUN, clearScore pulse, win=0, isGameComplete=0, tick counter=0.
- goodColl, badColl and clearScore are never high for two consecutive cycles.
- moveTick is never high outside RUN.

Optional Feature:
- Macro GAME_SPEEDUP_EN.
- Defined:
  - The RUN tick period becomes max(TICK_DIV - currScore[6:3], 2), sampled at each counter wrap.
  - The snake gets one cycle faster per 8 points.
- Undefined:
  - The period is fixed at TICK_DIV.
  - currScore is used only for the win check.

Test Plan (TICK_DIV=4, MAX_SCORE=3, OVER_HOLD=2; the bench models score_tracker):
- Reset then idle for 10 cycles -> gameState=00, all pulse outputs 0. Then startBtn high 1 cycle -> gameState=01, clearScore exactly one pulse, moveTick at cycles 4, 8, 12 after entry.
- RUN, appleHit held 5 cycles -> exactly one goodColl pulse, one cycle after the rise. Then appleHit and wallHit rise together -> badColl=1, goodColl=0, gameState=11, isGameComplete=1, win=0.
- RUN, three apple hits (currScore reaches 3) -> gameState=11 and win=1 one cycle after currScore=3; no badColl.
- RUN, pauseBtn pulse at counter=2 -> gameState=10, no moveTick for 20 cycles, selfHit pulse ignored. Second pause pulse -> RUN; the next moveTick arrives 2 cycles later.
- OVER, startBtn pulse 1 cycle after entry -> ignored, gameState stays 11. startBtn pulse after 3 cycles -> gameState=01, clearScore pulse, win=0.
- Assert nRst=0 for 1 cycle in RUN with the counter mid-count -> next cycle gameState=00, all outputs 0. With GAME_SPEEDUP_EN and currScore=16 -> moveTick period 2.
